// File: rtl/mcycle_pkg.sv
// mcycle_pkg: shared constants, entry layout and helpers for the multi-cycle
// write-back buffer (mcycle_wb_buffer / mcycle_wb_fifo).
package mcycle_pkg;

    localparam int REG_ADDR_W      = 4;
    localparam int NUM_REGS        = 16;
    localparam int MCYCLE_WB_DEPTH = 4;
    localparam int MCYCLE_WB_WIDTH = 32;

    // Layout of one queued result at the default data width.
    typedef struct packed {
        logic [REG_ADDR_W-1:0]      wa3;
        logic [MCYCLE_WB_WIDTH-1:0] data;
    } mcycle_wb_entry_t;

    // One-hot register mask used by the scoreboard set/clear paths.
    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] addr);
        logic [NUM_REGS-1:0] one_s;
        one_s = {{(NUM_REGS-1){1'b0}}, 1'b1};
        return one_s << addr;
    endfunction

endpackage

// File: rtl/mcycle_wb_fifo.sv
// mcycle_wb_fifo: result queue for the write-back buffer. Holds {wa3, data}
// entries, tracks count/full/empty and raises a sticky overflow when a push
// arrives while full and no pop frees a slot in the same cycle.
module mcycle_wb_fifo
    import mcycle_pkg::*;
#(
    parameter int DEPTH = MCYCLE_WB_DEPTH,
    parameter int width = MCYCLE_WB_WIDTH
) (
    input  logic                  CLK,
    input  logic                  Reset_n,
    input  logic                  Push,
    input  logic [REG_ADDR_W-1:0] PushWA3,
    input  logic [width-1:0]      PushData,
    input  logic                  Pop,
    output logic [REG_ADDR_W-1:0] HeadWA3,
    output logic [width-1:0]      HeadData,
    output logic                  Full,
    output logic                  Empty,
    output logic                  Overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [REG_ADDR_W-1:0] wa_mem_r   [DEPTH];
    logic [width-1:0]      data_mem_r [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_r;
    logic [PTR_W-1:0]      rd_ptr_r;
    logic [CNT_W-1:0]      count_r;
    logic                  overflow_r;

    logic full_s;
    logic empty_s;
    logic pop_s;
    logic push_ok_s;
    logic ovf_set_s;

    assign full_s    = (count_r == CNT_W'(DEPTH));
    assign empty_s   = (count_r == {CNT_W{1'b0}});
    // A pop never underflows; a pop in the same cycle frees a slot for a push.
    assign pop_s     = Pop & ~empty_s;
    assign push_ok_s = Push & (~full_s | pop_s);
    assign ovf_set_s = Push & full_s & ~pop_s;

    // Entry storage: written at the tail on an accepted push, cleared on reset.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                wa_mem_r[i]   <= {REG_ADDR_W{1'b0}};
                data_mem_r[i] <= {width{1'b0}};
            end
        end else if (push_ok_s) begin
            wa_mem_r[wr_ptr_r]   <= PushWA3;
            data_mem_r[wr_ptr_r] <= PushData;
        end
    end

    // Pointers wrap naturally modulo DEPTH; count tracks occupancy.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_ok_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Sticky overflow: once a result is dropped it stays visible until reset.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            overflow_r <= 1'b0;
        end else if (ovf_set_s) begin
            overflow_r <= 1'b1;
        end
    end

    assign HeadWA3  = wa_mem_r[rd_ptr_r];
    assign HeadData = data_mem_r[rd_ptr_r];
    assign Full     = full_s;
    assign Empty    = empty_s;
    assign Overflow = overflow_r;

endmodule

// File: rtl/mcycle_wb_buffer.sv
// mcycle_wb_buffer: write-back buffer and scoreboard for the multi-cycle
// multiply/divide unit. Queues completed results and drains them into
// register-file port 3 in cycles the main pipeline leaves the port free.
// Tracks destinations with an outstanding multi-cycle op and flags RAW/WAW
// hazards for decode.
// Optional feature: define MCYCLE_WB_BYPASS_EN to let a result arriving into
// an empty queue with a free port be written in its arrival cycle.
module mcycle_wb_buffer
    import mcycle_pkg::*;
#(
    parameter int DEPTH = MCYCLE_WB_DEPTH,
    parameter int width = MCYCLE_WB_WIDTH
) (
    input  logic                  CLK,
    input  logic                  Reset_n,
    input  logic                  MStart,
    input  logic [REG_ADDR_W-1:0] MStartWA3,
    input  logic                  MPushIn,
    input  logic [REG_ADDR_W-1:0] MCycleWA3,
    input  logic [width-1:0]      MResult,
    input  logic                  PipeRegWrite,
    input  logic [REG_ADDR_W-1:0] RA1,
    input  logic [REG_ADDR_W-1:0] RA2,
    input  logic [REG_ADDR_W-1:0] RA3,
    input  logic                  DecodeRegWrite,
    input  logic [REG_ADDR_W-1:0] DecodeWA3,
    output logic                  WE3,
    output logic [REG_ADDR_W-1:0] WA3,
    output logic [width-1:0]      WD3,
    output logic                  Hazard,
    output logic                  Full,
    output logic [NUM_REGS-1:0]   Pending,
    output logic                  Overflow
);

    logic                  fifo_push_s;
    logic                  fifo_pop_s;
    logic [REG_ADDR_W-1:0] head_wa3_s;
    logic [width-1:0]      head_data_s;
    logic                  fifo_full_s;
    logic                  fifo_empty_s;
    logic                  fifo_ovf_s;

    logic                  bypass_s;
    logic                  we3_s;
    logic [REG_ADDR_W-1:0] wa3_s;
    logic [width-1:0]      wd3_s;

    logic [NUM_REGS-1:0]   pending_r;
    logic [NUM_REGS-1:0]   pending_nxt_s;
    logic [NUM_REGS-1:0]   clr_mask_s;
    logic [NUM_REGS-1:0]   set_mask_s;

    mcycle_wb_fifo #(
        .DEPTH (DEPTH),
        .width (width)
    ) u_fifo (
        .CLK      (CLK),
        .Reset_n  (Reset_n),
        .Push     (fifo_push_s),
        .PushWA3  (MCycleWA3),
        .PushData (MResult),
        .Pop      (fifo_pop_s),
        .HeadWA3  (head_wa3_s),
        .HeadData (head_data_s),
        .Full     (fifo_full_s),
        .Empty    (fifo_empty_s),
        .Overflow (fifo_ovf_s)
    );

    // Drain arbitration: the pipeline always owns the port when it writes;
    // otherwise the queue head (or, with bypass, a fresh result) is written.
    always_comb begin
        bypass_s    = 1'b0;
        fifo_push_s = MPushIn;
        we3_s       = 1'b0;
        wa3_s       = {REG_ADDR_W{1'b0}};
        wd3_s       = {width{1'b0}};
`ifdef MCYCLE_WB_BYPASS_EN
        // Only an empty queue may be bypassed, otherwise ordering would break.
        if (MPushIn && fifo_empty_s && !PipeRegWrite) begin
            bypass_s    = 1'b1;
            fifo_push_s = 1'b0;
            we3_s       = 1'b1;
            wa3_s       = MCycleWA3;
            wd3_s       = MResult;
        end else
`endif
        if (!PipeRegWrite && !fifo_empty_s) begin
            we3_s = 1'b1;
            wa3_s = head_wa3_s;
            wd3_s = head_data_s;
        end else begin
            we3_s = 1'b0;
            wa3_s = {REG_ADDR_W{1'b0}};
            wd3_s = {width{1'b0}};
        end
    end

    assign fifo_pop_s = we3_s & ~bypass_s;

    // Scoreboard next state: clear the written register, then apply the new
    // launch so a same-register set wins over the clear.
    always_comb begin
        clr_mask_s    = we3_s  ? reg_onehot(wa3_s)     : {NUM_REGS{1'b0}};
        set_mask_s    = MStart ? reg_onehot(MStartWA3) : {NUM_REGS{1'b0}};
        pending_nxt_s = (pending_r & ~clr_mask_s) | set_mask_s;
    end

    // Scoreboard register: one bit per architectural register.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            pending_r <= {NUM_REGS{1'b0}};
        end else begin
            pending_r <= pending_nxt_s;
        end
    end

    assign WE3      = we3_s;
    assign WA3      = wa3_s;
    assign WD3      = wd3_s;
    assign Full     = fifo_full_s;
    assign Overflow = fifo_ovf_s;
    assign Pending  = pending_r;
    // Hazard looks only at registered state: a launch this cycle is seen next cycle.
    assign Hazard   = pending_r[RA1] | pending_r[RA2] | pending_r[RA3]
                    | (DecodeRegWrite & pending_r[DecodeWA3]);

endmodule

// File: tb/tb_mcycle_wb_buffer.sv
// Bench for mcycle_wb_buffer: directed scenarios plus randomized traffic,
// compared every cycle against a queue-based model of the buffer.
module tb_mcycle_wb_buffer;

    localparam int DEPTH = 4;
    localparam int W     = 32;

    logic          CLK = 1'b0;
    logic          Reset_n;
    logic          MStart;
    logic [3:0]    MStartWA3;
    logic          MPushIn;
    logic [3:0]    MCycleWA3;
    logic [W-1:0]  MResult;
    logic          PipeRegWrite;
    logic [3:0]    RA1, RA2, RA3;
    logic          DecodeRegWrite;
    logic [3:0]    DecodeWA3;
    logic          WE3;
    logic [3:0]    WA3;
    logic [W-1:0]  WD3;
    logic          Hazard;
    logic          Full;
    logic [15:0]   Pending;
    logic          Overflow;

    always #5 CLK = ~CLK;

    mcycle_wb_buffer #(.DEPTH(DEPTH), .width(W)) dut (
        .CLK(CLK), .Reset_n(Reset_n),
        .MStart(MStart), .MStartWA3(MStartWA3),
        .MPushIn(MPushIn), .MCycleWA3(MCycleWA3), .MResult(MResult),
        .PipeRegWrite(PipeRegWrite),
        .RA1(RA1), .RA2(RA2), .RA3(RA3),
        .DecodeRegWrite(DecodeRegWrite), .DecodeWA3(DecodeWA3),
        .WE3(WE3), .WA3(WA3), .WD3(WD3),
        .Hazard(Hazard), .Full(Full), .Pending(Pending), .Overflow(Overflow)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: queued {wa3, data} results, scoreboard bits, sticky overflow.
    logic [35:0] mq[$];
    logic [15:0] m_pend;
    bit          m_ovf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pend = 16'h0000;
        m_ovf  = 1'b0;
    endtask

    // One clock cycle: drive inputs, compare all outputs to the model, advance model.
    task automatic step(input bit ms, input logic [3:0] msa,
                        input bit mp, input logic [3:0] mca, input logic [31:0] mr,
                        input bit pipe, input logic [3:0] r1, input logic [3:0] r2,
                        input logic [3:0] r3, input bit drw, input logic [3:0] dwa);
        bit          byp;
        bit          e_we;
        logic [3:0]  e_wa;
        logic [31:0] e_wd;
        bit          e_hz;
        @(negedge CLK);
        MStart = ms; MStartWA3 = msa; MPushIn = mp; MCycleWA3 = mca; MResult = mr;
        PipeRegWrite = pipe; RA1 = r1; RA2 = r2; RA3 = r3;
        DecodeRegWrite = drw; DecodeWA3 = dwa;
        #1;
        byp = 1'b0;
`ifdef MCYCLE_WB_BYPASS_EN
        byp = mp && (mq.size() == 0) && !pipe;
`endif
        if (byp) begin
            e_we = 1'b1; e_wa = mca; e_wd = mr;
        end else if (!pipe && mq.size() > 0) begin
            e_we = 1'b1; e_wa = mq[0][35:32]; e_wd = mq[0][31:0];
        end else begin
            e_we = 1'b0; e_wa = 4'h0; e_wd = 32'h0;
        end
        e_hz = m_pend[r1] | m_pend[r2] | m_pend[r3] | (drw & m_pend[dwa]);
        chk("WE3", {31'b0, WE3}, {31'b0, e_we});
        chk("WA3", {28'b0, WA3}, {28'b0, e_wa});
        chk("WD3", WD3, e_wd);
        chk("Hazard", {31'b0, Hazard}, {31'b0, e_hz});
        chk("Full", {31'b0, Full}, {31'b0, mq.size() == DEPTH});
        chk("Pending", {16'b0, Pending}, {16'b0, m_pend});
        chk("Overflow", {31'b0, Overflow}, {31'b0, m_ovf});
        // Advance the model to the state after the coming rising edge.
        if (!byp) begin
            if (e_we) void'(mq.pop_front());
            if (mp) begin
                if (mq.size() < DEPTH) mq.push_back({mca, mr});
                else m_ovf = 1'b1;
            end
        end
        if (e_we) m_pend[e_wa] = 1'b0;
        if (ms) m_pend[msa] = 1'b1;
    endtask

    task automatic idle(input bit pipe, input logic [3:0] r1, input bit drw, input logic [3:0] dwa);
        step(1'b0, 4'h0, 1'b0, 4'h0, 32'h0, pipe, r1, r1, r1, drw, dwa);
    endtask

    task automatic push(input logic [3:0] wa, input logic [31:0] d, input bit pipe);
        step(1'b0, 4'h0, 1'b1, wa, d, pipe, 4'h0, 4'h0, 4'h0, 1'b0, 4'h0);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        Reset_n = 1'b0;
        model_reset();
        @(negedge CLK);
        Reset_n = 1'b1;
    endtask

    int nw;

    initial begin
        Reset_n = 1'b0;
        MStart = 1'b0; MStartWA3 = 4'h0; MPushIn = 1'b0; MCycleWA3 = 4'h0;
        MResult = 32'h0; PipeRegWrite = 1'b0; RA1 = 4'h0; RA2 = 4'h0; RA3 = 4'h0;
        DecodeRegWrite = 1'b0; DecodeWA3 = 4'h0;
        model_reset();
        #3;
        chk("rst_WE3", {31'b0, WE3}, 32'd0);
        chk("rst_Pending", {16'b0, Pending}, 32'd0);
        chk("rst_Full", {31'b0, Full}, 32'd0);
        chk("rst_Hazard", {31'b0, Hazard}, 32'd0);
        chk("rst_Overflow", {31'b0, Overflow}, 32'd0);
        @(negedge CLK);
        Reset_n = 1'b1;

        // Single op: launch r5, result 8 cycles later, hazard throughout.
        step(1'b1, 4'd5, 1'b0, 4'h0, 32'h0, 1'b0, 4'd5, 4'd0, 4'd0, 1'b0, 4'h0);
        for (int i = 0; i < 8; i++) begin
            idle(1'b0, 4'd5, 1'b0, 4'h0);
            chk("single_hazard_wait", {31'b0, Hazard}, 32'd1);
        end
        step(1'b0, 4'h0, 1'b1, 4'd5, 32'h0000_00C8, 1'b0, 4'd5, 4'd0, 4'd0, 1'b0, 4'h0);
        chk("single_hazard_push", {31'b0, Hazard}, 32'd1);
`ifdef MCYCLE_WB_BYPASS_EN
        chk("single_we_bypass", {31'b0, WE3}, 32'd1);
        chk("single_wd_bypass", WD3, 32'h0000_00C8);
`else
        chk("single_we_push", {31'b0, WE3}, 32'd0);
        idle(1'b0, 4'd5, 1'b0, 4'h0);
        chk("single_we", {31'b0, WE3}, 32'd1);
        chk("single_wa", {28'b0, WA3}, 32'd5);
        chk("single_wd", WD3, 32'h0000_00C8);
        chk("single_hazard_drain", {31'b0, Hazard}, 32'd1);
`endif
        idle(1'b0, 4'd5, 1'b0, 4'h0);
        chk("single_pend5", {31'b0, Pending[5]}, 32'd0);
        chk("single_hazard_done", {31'b0, Hazard}, 32'd0);

        // Port contention: two results arrive while the pipeline holds the port.
        push(4'd7, 32'h1111_0007, 1'b1);
        chk("cont_we0", {31'b0, WE3}, 32'd0);
        push(4'd9, 32'h2222_0009, 1'b1);
        chk("cont_we1", {31'b0, WE3}, 32'd0);
        idle(1'b1, 4'h0, 1'b0, 4'h0);
        chk("cont_we2", {31'b0, WE3}, 32'd0);
        idle(1'b0, 4'h0, 1'b0, 4'h0);
        chk("cont_first_wa", {28'b0, WA3}, 32'd7);
        chk("cont_first_wd", WD3, 32'h1111_0007);
        idle(1'b0, 4'h0, 1'b0, 4'h0);
        chk("cont_second_wa", {28'b0, WA3}, 32'd9);
        chk("cont_second_wd", WD3, 32'h2222_0009);
        idle(1'b0, 4'h0, 1'b0, 4'h0);
        chk("cont_empty_we", {31'b0, WE3}, 32'd0);

        // Fill and overflow.
        for (int i = 0; i < 4; i++) push(4'(i + 1), 32'(100 + i), 1'b1);
        chk("fill_full_before", {31'b0, Full}, 32'd0);
        push(4'd15, 32'hDEAD_BEEF, 1'b1);
        chk("fill_full", {31'b0, Full}, 32'd1);
        idle(1'b1, 4'h0, 1'b0, 4'h0);
        chk("fill_overflow", {31'b0, Overflow}, 32'd1);
        nw = 0;
        for (int i = 0; i < 6; i++) begin
            idle(1'b0, 4'h0, 1'b0, 4'h0);
            nw += int'(WE3);
        end
        chk("fill_writes", nw, 32'd4);

        // Full with simultaneous push and pop.
        do_reset();
        for (int i = 0; i < 4; i++) push(4'(i + 8), 32'(200 + i), 1'b1);
        push(4'd12, 32'h0000_0CCC, 1'b0);
        chk("fullpp_full", {31'b0, Full}, 32'd1);
        chk("fullpp_we", {31'b0, WE3}, 32'd1);
        idle(1'b1, 4'h0, 1'b0, 4'h0);
        chk("fullpp_full_after", {31'b0, Full}, 32'd1);
        chk("fullpp_ovf", {31'b0, Overflow}, 32'd0);
        for (int i = 0; i < 5; i++) idle(1'b0, 4'h0, 1'b0, 4'h0);

        // Set/clear collision on r4.
        do_reset();
        push(4'd4, 32'h0000_0044, 1'b1);
        step(1'b1, 4'd4, 1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 4'h0);
        chk("coll_we", {31'b0, WE3}, 32'd1);
        chk("coll_wa", {28'b0, WA3}, 32'd4);
        idle(1'b1, 4'h0, 1'b1, 4'd4);
        chk("coll_pend4", {31'b0, Pending[4]}, 32'd1);
        chk("coll_hazard", {31'b0, Hazard}, 32'd1);

        // Reset mid-drain.
        do_reset();
        step(1'b1, 4'd4, 1'b0, 4'h0, 32'h0, 1'b1, 4'h0, 4'h0, 4'h0, 1'b0, 4'h0);
        step(1'b1, 4'd5, 1'b1, 4'd4, 32'h0000_0A04, 1'b1, 4'h0, 4'h0, 4'h0, 1'b0, 4'h0);
        push(4'd5, 32'h0000_0A05, 1'b1);
        idle(1'b0, 4'h0, 1'b0, 4'h0);
        chk("rmd_we_before", {31'b0, WE3}, 32'd1);
        chk("rmd_pend_before", {16'b0, Pending}, 32'h0000_0030);
        #2;
        Reset_n = 1'b0;
        #1;
        chk("rmd_we", {31'b0, WE3}, 32'd0);
        chk("rmd_pend", {16'b0, Pending}, 32'd0);
        chk("rmd_full", {31'b0, Full}, 32'd0);
        model_reset();
        @(negedge CLK);
        @(negedge CLK);
        Reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            idle(1'b0, 4'h0, 1'b0, 4'h0);
            chk("rmd_no_write", {31'b0, WE3}, 32'd0);
        end

        // Randomized traffic: a light phase, then a port-heavy phase.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            bit heavy;
            heavy = (i >= 2000);
            if (i == 2000) do_reset();
            step($urandom_range(0, 3) == 0, 4'($urandom),
                 $urandom_range(0, 9) < (heavy ? 5 : 3), 4'($urandom), 32'($urandom),
                 $urandom_range(0, 9) < (heavy ? 8 : 5),
                 4'($urandom), 4'($urandom), 4'($urandom),
                 $urandom_range(0, 1) == 1, 4'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mcycle_wb_buffer.md
# mcycle_wb_buffer

Write-back buffer and scoreboard for the multi-cycle multiply/divide unit: consumes its one-cycle completion pulse, destination tag and result, and drains them into the register-file write port. Drains only in cycles the main pipeline does not use that port. Tracks which destination registers have an outstanding multi-cycle operation and raises a decode-stage stall on RAW/WAW hits. Sits between the multi-cycle unit's output side and the register file's third write port.

## Interface
- DEPTH, 4, result FIFO entries (power of two, ≥2)
- width, 32, data width of results
- CLK  in  1  clock, rising edge
- Reset_n  in  1  asynchronous, active-low reset
- MStart  in  1  decode launches a multi-cycle op this cycle
- MStartWA3  in  4  destination of the launched op
- MPushIn  in  1  multi-cycle result valid (single-cycle pulse)
- MCycleWA3  in  4  destination tag of that result
- MResult  in  width  result value
- PipeRegWrite  in  1  main pipeline owns the write port this cycle
- RA1, RA2, RA3  in  4 each  source registers of the instruction in decode
- DecodeRegWrite  in  1  decode instruction writes a register
- DecodeWA3  in  4  its destination
- WE3  out  1  write enable to register-file port 3
- WA3  out  4  write address
- WD3  out  width  write data
- Hazard  out  1  decode must stall
- Full  out  1  FIFO holds DEPTH entries; decode must not issue MStart
- Pending  out  16  scoreboard bit per register
- Overflow  out  1  sticky: a result arrived while full

## Operation
- FIFO: push {MCycleWA3, MResult} on MPushIn; pop head when drained.
- Drain rule: WE3 = ~PipeRegWrite & (count>0); WA3/WD3 = head entry; pop on that edge. Pipeline always has priority.
- WE3=0 ⇒ WA3=0, WD3=0.
- Push and pop in same cycle: both take effect; count unchanged; legal when full (pop frees slot first).
- Push while full and no pop: entry dropped, Overflow set, held until reset.
- Scoreboard: MStart sets Pending[MStartWA3]; WE3 clears Pending[WA3] at the edge. Set and clear of same register in one cycle: set wins.
- Hazard = Pending[RA1] | Pending[RA2] | Pending[RA3] | (DecodeRegWrite & Pending[DecodeWA3]). Combinational from registered Pending; MStart this cycle does not affect Hazard until next cycle.
- Full = (count==DEPTH), combinational from count.

## Timing
- Reset (Reset_n low, async): count, pointers, Pending, Overflow = 0; WE3/WA3/WD3 = 0; Hazard=0; Full=0. Queued results are discarded; the multi-cycle unit is reset by the same signal.
- MPushIn at cycle t, port free: WE3 at t+1 (registered path), Pending cleared at edge ending t+1.
- Port blocked by PipeRegWrite for N cycles: drain delayed N cycles; order preserved (FIFO).
- Pointers wrap modulo DEPTH; count width log2(DEPTH)+1.

## Configuration
- MCYCLE_WB_BYPASS_EN defined: when MPushIn=1, count==0 and PipeRegWrite=0, result goes straight to WE3/WA3/WD3 in cycle t (not enqueued), Pending cleared at the end of t. With count>0 the normal FIFO path applies to keep ordering.
- Undefined: all results pass through the FIFO; minimum latency 1 cycle; no combinational MPushIn→WE3 path.

## Structure
- Package mcycle_pkg: REG_ADDR_W=4, NUM_REGS=16, MCYCLE_WB_DEPTH default, the FIFO entry struct {wa3, data}.
- Sub-module mcycle_wb_fifo: storage, pointers, count, Full/empty, push/pop/overflow. Scoreboard, drain arbitration and hazard logic stay in the top.

## Test plan
- Reset mid-drain: 2 entries queued, Pending=16'h0030, pull Reset_n low → WE3=0, Pending=0, Full=0 immediately; no writes after release.
- Single op: MStart WA3=5; 8 cycles later MPushIn WA3=5, MResult=32'h0000_00C8, PipeRegWrite=0 → Hazard=1 for RA1=5 throughout; WE3=1, WA3=5, WD3=C8 next cycle (same cycle with bypass); Pending[5]=0 after.
- Port contention: PipeRegWrite held 1 for 3 cycles while 2 results (R2=7, R3=9) arrive → no WE3 during block; then R2, R3 written in consecutive cycles, in that order.
- Fill and overflow (DEPTH=4): 4 pushes with PipeRegWrite=1 → Full=1; 5th push → dropped, Overflow=1; release port → exactly 4 writes.
- Full with simultaneous push/pop: count=4, PipeRegWrite=0, MPushIn=1 → push accepted, count stays 4, Overflow stays 0.
- Set/clear collision: WE3 draining WA3=4 while MStart WA3=4 → Pending[4]=1 afterwards; DecodeRegWrite with DecodeWA3=4 → Hazard=1.
